cp0_exception_unit: RTL and testbench
=====================================

# cp0_exception_unit

CP0 register file and precise-exception commit point at the WB end of the pipeline. It consumes the exception vector, delay-slot flag, PC and MTC0 data carried down the pipeline registers. It resolves exception priority and updates Status/Cause/EPC/BadVAddr/Count/Compare. It issues the pipeline flush and redirect PC, and raises the interrupt-pending flag that the decode stage folds into the Interrupt exception bit.

## Interface
- EXC_VECTOR, 32'hBFC0_0380, general exception entry PC (BEV=1).
- clk  in  1  pipeline clock.
- rst  in  1  synchronous reset, active-high.
- WB_ExceptType  in  9  {Interrupt, WrongAddressinIF, ReservedInstruction, Overflow, Syscall, Break, Eret, WrWrongAddressinMEM, RdWrongAddressinMEM}, MSB first.
- WB_PC  in  32  PC of the instruction in WB.
- WB_IsDelaySlot  in  1  WB instruction sits in a branch delay slot.
- WB_ALUOut  in  32  effective data address (load/store bad address).
- WB_CP0Wr  in  1  MTC0 write enable.
- WB_Dst  in  5  MTC0 destination register number (sel 0 only).
- WB_OutB  in  32  MTC0 write data.
- CP0_RdAddr  in  5  MFC0 read register number.
- CP0_RdData  out  32  MFC0 read data.
- Ext_Interrupt  in  6  hardware interrupt lines HW5..HW0, level-sensitive.
- Exc_Flush  out  1  flush IF..MEM and redirect this cycle.
- Exc_NPC  out  32  redirect PC, valid when Exc_Flush=1.
- CP0_IntPending  out  1  enabled, unmasked interrupt pending.

## Operation
- Implemented registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14). All other numbers read 0 and ignore writes.
- Status: BEV[22] reads 1 and is read-only. IM[15:8], EXL[1] and IE[0] are writable. All other bits read 0.
- Cause: BD[31] and TI[30] are read-only. IP[15:10] = {TI|HW5, HW4..HW0}, sampled from Ext_Interrupt each cycle. IP[9:8] are software-writable. ExcCode[6:2] is read-only. All other bits read 0.
- Exception priority, highest first. ExcCode and BadVAddr source per level:
  - Interrupt: 0x00.
  - WrongAddressinIF: 0x04, BadVAddr=WB_PC.
  - ReservedInstruction: 0x0A.
  - Overflow: 0x0C.
  - Syscall: 0x08.
  - Break: 0x09.
  - RdWrongAddressinMEM: 0x04, BadVAddr=WB_ALUOut.
  - WrWrongAddressinMEM: 0x05, BadVAddr=WB_ALUOut.
  - Eret: lowest priority.
- Exception taken (any bit except Eret):
  - Exc_Flush=1, Exc_NPC=EXC_VECTOR.
  - ExcCode is written.
  - BadVAddr is written only for address errors.
  - If EXL=0: EPC = WB_IsDelaySlot ? WB_PC-4 : WB_PC, BD=WB_IsDelaySlot.
  - If EXL=1: EPC and BD are unchanged.
  - EXL is set to 1.
- Eret alone: Exc_Flush=1, Exc_NPC=EPC (current register value), EXL is cleared.
- MTC0 is suppressed whenever Exc_Flush=1.
- MTC0 Compare clears TI.
- MTC0 Count loads the value and resets the half-rate tick.
- CP0_IntPending = |(IP & IM) & IE & ~EXL.
- Count increments by 1 every second clk cycle and wraps 0xFFFF_FFFF→0.
- TI is set on the edge where Count==Compare. A same-cycle Compare write takes priority and TI ends 0.
- CP0_RdData is a combinational read. When WB_CP0Wr is active, WB_Dst==CP0_RdAddr and Exc_Flush=0, CP0_RdData returns WB_OutB masked to the target register's writable bits (bypass).

## Timing
- Exc_Flush, Exc_NPC, CP0_RdData and CP0_IntPending are combinational from the current inputs and registers.
- All CP0 register updates land at the next rising clk edge. Zero-cycle flush latency, one-cycle state latency.
- Reset, checked at the clk edge:
  - Status=0x0040_0000, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, tick=0.
  - While rst=1: Exc_Flush=0, Exc_NPC=EXC_VECTOR, CP0_IntPending=0.
- Reset mid-operation discards any pending update in that cycle.
- Count==Compare==0 immediately after reset sets TI on the first edge after reset deasserts.
- An interrupt line dropping before WB does not cancel an Interrupt exception already tagged in WB_ExceptType.
- A CP0_IntPending rise is visible the cycle after the IP/IM/IE/EXL update.

## Test plan
- Overflow, WB_PC=0x8000_1000, not delay slot, EXL=0 → Exc_Flush=1 and Exc_NPC=0xBFC0_0380 that cycle; next cycle EPC=0x8000_1000, ExcCode=0x0C, EXL=1, BD=0.
- RdWrongAddressinMEM in a delay slot, WB_PC=0x8000_2004, WB_ALUOut=0x0000_0003 → EPC=0x8000_2000, BD=1, BadVAddr=0x3, ExcCode=0x04.
- Syscall and RdWrongAddressinMEM together → ExcCode=0x08, BadVAddr unchanged. A second exception with EXL=1 → EPC unchanged.
- Eret with EPC=0x8000_3000 → Exc_NPC=0x8000_3000, EXL=0 next cycle. Same cycle as Break → Break wins, EXL remains 1.
- MTC0 Compare=10 with Count=0, IM[7]=1, IE=1 → TI=1 and CP0_IntPending=1 about 20 cycles later; MTC0 Compare → TI=0.
- MTC0 Status=0xFFFF_FFFF with CP0_RdAddr=12 → same-cycle CP0_RdData=0x0040_FF03; MTC0 together with Overflow → Status unchanged.

Source files
------------

// File: rtl/cp0_exception_unit_if.sv
// WB-stage to CP0 signal bundle: exception tags, MTC0/MFC0 access, interrupts,
// and the flush/redirect and interrupt-pending results.
interface cp0_exception_unit_if;
  logic [8:0]  WB_ExceptType;
  logic [31:0] WB_PC;
  logic        WB_IsDelaySlot;
  logic [31:0] WB_ALUOut;
  logic        WB_CP0Wr;
  logic [4:0]  WB_Dst;
  logic [31:0] WB_OutB;
  logic [4:0]  CP0_RdAddr;
  logic [31:0] CP0_RdData;
  logic [5:0]  Ext_Interrupt;
  logic        Exc_Flush;
  logic [31:0] Exc_NPC;
  logic        CP0_IntPending;

  modport master (
    output WB_ExceptType, WB_PC, WB_IsDelaySlot, WB_ALUOut, WB_CP0Wr, WB_Dst,
           WB_OutB, CP0_RdAddr, Ext_Interrupt,
    input  CP0_RdData, Exc_Flush, Exc_NPC, CP0_IntPending
  );

  modport slave (
    input  WB_ExceptType, WB_PC, WB_IsDelaySlot, WB_ALUOut, WB_CP0Wr, WB_Dst,
           WB_OutB, CP0_RdAddr, Ext_Interrupt,
    output CP0_RdData, Exc_Flush, Exc_NPC, CP0_IntPending
  );
endinterface

// File: rtl/cp0_exception_unit.sv
// CP0 register file and precise-exception commit point at the end of WB:
// priority resolution, Status/Cause/EPC/BadVAddr/Count/Compare, flush/redirect.
module cp0_exception_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input logic                 clk,
  input logic                 rst,
  cp0_exception_unit_if.slave bus
);
  localparam logic [4:0]  REG_BADVADDR = 5'd8;
  localparam logic [4:0]  REG_COUNT    = 5'd9;
  localparam logic [4:0]  REG_COMPARE  = 5'd11;
  localparam logic [4:0]  REG_STATUS   = 5'd12;
  localparam logic [4:0]  REG_CAUSE    = 5'd13;
  localparam logic [4:0]  REG_EPC      = 5'd14;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] epc_q, epc_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic        ti_q, ti_d;
  logic [5:0]  hw_q, hw_d;
  logic [1:0]  sw_q, sw_d;
  logic [4:0]  exccode_q, exccode_d;
  logic        tick_q, tick_d;

  logic [8:0]  et;
  logic        exc_any, eret, flush, mtc0;
  logic        badv_ld;
  logic [4:0]  exc_code;
  logic [31:0] badv_val;
  logic [31:0] status_rd, cause_rd, rd_cur, rd_wmask;
  logic [7:0]  ip;

  assign et      = bus.WB_ExceptType;
  assign exc_any = (|et[8:3]) | (|et[1:0]);
  assign eret    = et[2];
  assign flush   = ~rst & (exc_any | eret);
  assign mtc0    = bus.WB_CP0Wr & ~flush;

  // Priority order differs from bit order: the MEM read fault (bit 0) outranks the write fault (bit 1).
  always_comb begin
    exc_code = '0;
    badv_ld  = 1'b0;
    badv_val = bus.WB_ALUOut;
    if (et[8]) begin
      exc_code = 5'h00;
    end else if (et[7]) begin
      exc_code = 5'h04;
      badv_ld  = 1'b1;
      badv_val = bus.WB_PC;
    end else if (et[6]) begin
      exc_code = 5'h0A;
    end else if (et[5]) begin
      exc_code = 5'h0C;
    end else if (et[4]) begin
      exc_code = 5'h08;
    end else if (et[3]) begin
      exc_code = 5'h09;
    end else if (et[0]) begin
      exc_code = 5'h04;
      badv_ld  = 1'b1;
    end else if (et[1]) begin
      exc_code = 5'h05;
      badv_ld  = 1'b1;
    end
  end

  assign status_rd = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_rd  = {bd_q, ti_q, 14'b0, ti_q | hw_q[5], hw_q[4:0], sw_q, 1'b0, exccode_q, 2'b0};
  assign ip        = cause_rd[15:8];

  always_comb begin
    rd_cur   = '0;
    rd_wmask = '0;
    unique case (bus.CP0_RdAddr)
      REG_BADVADDR: rd_cur = badvaddr_q;
      REG_COUNT:    begin rd_cur = count_q;   rd_wmask = '1; end
      REG_COMPARE:  begin rd_cur = compare_q; rd_wmask = '1; end
      REG_STATUS:   begin rd_cur = status_rd; rd_wmask = STATUS_WMASK; end
      REG_CAUSE:    begin rd_cur = cause_rd;  rd_wmask = CAUSE_WMASK; end
      REG_EPC:      begin rd_cur = epc_q;     rd_wmask = '1; end
      default:      ;
    endcase
  end

  // Bypass returns what the register will read after the in-flight MTC0 lands.
  assign bus.CP0_RdData = (mtc0 && bus.WB_Dst == bus.CP0_RdAddr)
                        ? ((bus.WB_OutB & rd_wmask) | (rd_cur & ~rd_wmask))
                        : rd_cur;
  assign bus.Exc_Flush      = flush;
  assign bus.Exc_NPC        = (rst | exc_any) ? EXC_VECTOR : epc_q;
  assign bus.CP0_IntPending = ~rst & (|(ip & im_q)) & ie_q & ~exl_q;

  always_comb begin
    badvaddr_d = badvaddr_q;
    count_d    = count_q;
    compare_d  = compare_q;
    epc_d      = epc_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ti_d       = ti_q;
    hw_d       = bus.Ext_Interrupt;
    sw_d       = sw_q;
    exccode_d  = exccode_q;
    tick_d     = ~tick_q;

    if (mtc0 && bus.WB_Dst == REG_COUNT) begin
      count_d = bus.WB_OutB;
      tick_d  = 1'b0;
    end else begin
      count_d = count_q + {31'b0, tick_q};
    end

    if (mtc0 && bus.WB_Dst == REG_COMPARE) begin
      compare_d = bus.WB_OutB;
      ti_d      = 1'b0;
    end else if (count_q == compare_q) begin
      ti_d = 1'b1;
    end

    if (exc_any) begin
      exccode_d = exc_code;
      if (badv_ld) badvaddr_d = badv_val;
      if (!exl_q) begin
        epc_d = bus.WB_IsDelaySlot ? (bus.WB_PC - 32'd4) : bus.WB_PC;
        bd_d  = bus.WB_IsDelaySlot;
      end
      exl_d = 1'b1;
    end else if (eret) begin
      exl_d = 1'b0;
    end else if (mtc0) begin
      unique case (bus.WB_Dst)
        REG_STATUS: begin
          im_d  = bus.WB_OutB[15:8];
          exl_d = bus.WB_OutB[1];
          ie_d  = bus.WB_OutB[0];
        end
        REG_CAUSE: sw_d  = bus.WB_OutB[9:8];
        REG_EPC:   epc_d = bus.WB_OutB;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      epc_q      <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      hw_q       <= '0;
      sw_q       <= '0;
      exccode_q  <= '0;
      tick_q     <= 1'b0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      epc_q      <= epc_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      hw_q       <= hw_d;
      sw_q       <= sw_d;
      exccode_q  <= exccode_d;
      tick_q     <= tick_d;
    end
  end
endmodule

// File: tb/tb_cp0_exception_unit.sv
// Scoreboard bench for cp0_exception_unit: a word-level CP0 model predicts each
// cycle's flush/redirect/read/interrupt outputs; a negedge monitor compares them.
module tb_cp0_exception_unit;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cp0_exception_unit_if bus();

  cp0_exception_unit #(.EXC_VECTOR(VEC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        flush;
    logic [31:0] npc;
    bit          npc_chk;
    logic [31:0] rd;
    bit          rd_chk;
    logic        ip;
  } exp_t;

  exp_t sbq[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // stimulus for the current cycle
  bit        s_rst;
  bit [8:0]  s_exc;
  bit [31:0] s_pc, s_alu, s_outb;
  bit        s_ds, s_wr;
  bit [4:0]  s_dst, s_rda;
  bit [5:0]  s_ext;

  // reference CP0 state, kept as architectural words
  bit [31:0] m_status, m_cause, m_epc, m_badv, m_count, m_compare;
  bit [5:0]  m_hw;
  int unsigned m_phase;

  // exception priority table: tag bit, ExcCode, BadVAddr source (0 none, 1 PC, 2 ALU)
  int unsigned pri_bit[8] = '{8, 7, 6, 5, 4, 3, 0, 1};
  bit [4:0]    pri_code[8] = '{5'h00, 5'h04, 5'h0A, 5'h0C, 5'h08, 5'h09, 5'h04, 5'h05};
  int unsigned pri_bv[8]  = '{0, 1, 0, 0, 0, 0, 2, 2};

  function automatic bit [31:0] m_read(bit [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return (m_status & 32'h0000_FF03) | 32'h0040_0000;
      5'd13:   return m_cause | {16'b0, m_hw | {m_cause[30], 5'b0}, 10'b0};
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit [31:0] m_wmask(bit [4:0] a);
    case (a)
      5'd9, 5'd11, 5'd14: return 32'hFFFF_FFFF;
      5'd12:   return 32'h0000_FF03;
      5'd13:   return 32'h0000_0300;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("flush", {31'b0, bus.Exc_Flush}, {31'b0, e.flush});
      chk("intpending", {31'b0, bus.CP0_IntPending}, {31'b0, e.ip});
      if (e.npc_chk) chk("npc", bus.Exc_NPC, e.npc);
      if (e.rd_chk) chk("rddata", bus.CP0_RdData, e.rd);
    end
  end

  task automatic drive();
    rst                = s_rst;
    bus.WB_ExceptType  = s_exc;
    bus.WB_PC          = s_pc;
    bus.WB_IsDelaySlot = s_ds;
    bus.WB_ALUOut      = s_alu;
    bus.WB_CP0Wr       = s_wr;
    bus.WB_Dst         = s_dst;
    bus.WB_OutB        = s_outb;
    bus.CP0_RdAddr     = s_rda;
    bus.Ext_Interrupt  = s_ext;
  endtask

  // Drive one cycle, predict its outputs, advance the model across the edge.
  task automatic apply();
    exp_t e;
    int found;
    bit eret, wr;
    bit [31:0] cause_now, old_count, old_compare, rdv, wm;
    bit [7:0] ipv;
    drive();
    found = -1;
    for (int i = 0; i < 8; i++)
      if (found < 0 && s_exc[pri_bit[i]]) found = i;
    eret      = s_exc[2];
    e.flush   = !s_rst && (found >= 0 || eret);
    e.npc     = (s_rst || found >= 0) ? VEC : m_epc;
    e.npc_chk = s_rst || e.flush;
    wr        = s_wr && !e.flush;
    rdv       = m_read(s_rda);
    wm        = m_wmask(s_rda);
    e.rd      = (wr && s_dst == s_rda) ? ((s_outb & wm) | (rdv & ~wm)) : rdv;
    e.rd_chk  = !s_rst;
    cause_now = m_read(5'd13);
    ipv       = cause_now[15:8];
    e.ip      = !s_rst && (|(ipv & m_status[15:8])) && m_status[0] && !m_status[1];
    sbq.push_back(e);

    if (s_rst) begin
      m_status = 0; m_cause = 0; m_epc = 0; m_badv = 0;
      m_count = 0; m_compare = 0; m_hw = 0; m_phase = 0;
    end else begin
      old_count   = m_count;
      old_compare = m_compare;
      m_hw = s_ext;
      if (wr && s_dst == 5'd9) begin
        m_count = s_outb;
        m_phase = 0;
      end else begin
        m_phase = m_phase + 1;
        if (m_phase % 2 == 0) m_count = m_count + 1;
      end
      if (wr && s_dst == 5'd11) begin
        m_compare   = s_outb;
        m_cause[30] = 1'b0;
      end else if (old_count == old_compare) begin
        m_cause[30] = 1'b1;
      end
      if (found >= 0) begin
        m_cause[6:2] = pri_code[found];
        if (pri_bv[found] == 1) m_badv = s_pc;
        if (pri_bv[found] == 2) m_badv = s_alu;
        if (!m_status[1]) begin
          m_epc       = s_ds ? s_pc - 32'd4 : s_pc;
          m_cause[31] = s_ds;
        end
        m_status[1] = 1'b1;
      end else if (eret) begin
        m_status[1] = 1'b0;
      end else if (wr) begin
        if (s_dst == 5'd12) m_status = s_outb & 32'h0000_FF03;
        if (s_dst == 5'd13) m_cause[9:8] = s_outb[9:8];
        if (s_dst == 5'd14) m_epc = s_outb;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit [4:0] rda);
    s_rst = 0; s_exc = 0; s_pc = 32'h8000_0000; s_ds = 0; s_alu = 0;
    s_wr = 0; s_dst = 0; s_outb = 0; s_rda = rda; s_ext = 0;
  endtask

  task automatic rd_cycle(input bit [4:0] rda);
    idle(rda);
    apply();
  endtask

  task automatic mtc0(input bit [4:0] dst, input bit [31:0] val, input bit [4:0] rda);
    idle(rda);
    s_wr = 1; s_dst = dst; s_outb = val;
    apply();
  endtask

  task automatic exc_cycle(input bit [8:0] exc, input bit [31:0] pc, input bit ds,
                           input bit [31:0] alu, input bit [4:0] rda);
    idle(rda);
    s_exc = exc; s_pc = pc; s_ds = ds; s_alu = alu;
    apply();
  endtask

  function automatic bit [4:0] pick_reg();
    bit [4:0] regs[6] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
    int unsigned k;
    k = $urandom_range(0, 6);
    if (k == 6) return 5'($urandom);
    return regs[k];
  endfunction

  initial begin
    idle(5'd12);
    s_rst = 1;
    drive();
    @(posedge clk);
    #1;
    repeat (3) begin idle(5'd12); s_rst = 1; apply(); end

    // TI rises on the first edge after reset (Count==Compare==0)
    rd_cycle(5'd13);
    rd_cycle(5'd13);

    // Status write-through bypass, then clear EXL for exception tests
    mtc0(5'd12, 32'hFFFF_FFFF, 5'd12);
    mtc0(5'd12, 32'h0000_FF01, 5'd12);

    // Overflow, not in delay slot
    exc_cycle(9'b0_0010_0000, 32'h8000_1000, 0, 32'h0, 5'd14);
    rd_cycle(5'd14); rd_cycle(5'd13); rd_cycle(5'd12);

    // RdWrongAddressinMEM in a delay slot
    mtc0(5'd12, 32'h0000_FF01, 5'd12);
    exc_cycle(9'b0_0000_0001, 32'h8000_2004, 1, 32'h0000_0003, 5'd8);
    rd_cycle(5'd14); rd_cycle(5'd13); rd_cycle(5'd8);

    // Syscall beats RdWrongAddress; EXL=1 keeps EPC
    exc_cycle(9'b0_0001_0001, 32'h8000_5000, 0, 32'h0000_0777, 5'd13);
    rd_cycle(5'd13); rd_cycle(5'd8); rd_cycle(5'd14);

    // Eret redirects to EPC; Eret with Break takes Break
    mtc0(5'd14, 32'h8000_3000, 5'd14);
    exc_cycle(9'b0_0000_0100, 32'h8000_6000, 0, 32'h0, 5'd12);
    rd_cycle(5'd12);
    mtc0(5'd12, 32'h0000_FF03, 5'd12);
    exc_cycle(9'b0_0000_1100, 32'h8000_6004, 0, 32'h0, 5'd12);
    rd_cycle(5'd12); rd_cycle(5'd13);

    // Timer interrupt from Count/Compare
    mtc0(5'd9, 32'h0, 5'd9);
    mtc0(5'd11, 32'd10, 5'd13);
    mtc0(5'd12, 32'h0000_8001, 5'd13);
    repeat (25) rd_cycle(5'd13);
    mtc0(5'd11, 32'hFFFF_0000, 5'd13);
    rd_cycle(5'd13);

    // MTC0 suppressed by a same-cycle exception
    idle(5'd12);
    s_exc = 9'b0_0010_0000; s_wr = 1; s_dst = 5'd12; s_outb = 32'hFFFF_FFFF;
    apply();
    rd_cycle(5'd12);

    // Count wrap
    mtc0(5'd9, 32'hFFFF_FFFE, 5'd9);
    repeat (6) rd_cycle(5'd9);

    // Interrupt tag survives the line dropping
    mtc0(5'd12, 32'h0000_0401, 5'd12);
    idle(5'd13); s_ext = 6'b00_0001; apply();
    idle(5'd13); s_ext = 6'b00_0001; apply();
    exc_cycle(9'b1_0000_0000, 32'h8000_7000, 0, 32'h0, 5'd13);
    rd_cycle(5'd13); rd_cycle(5'd14);

    // Reset mid-operation discards a pending write
    idle(5'd12); s_rst = 1; s_wr = 1; s_dst = 5'd12; s_outb = 32'hFFFF_FFFF;
    apply();
    rd_cycle(5'd12); rd_cycle(5'd13);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      int unsigned r;
      idle(pick_reg());
      r = $urandom_range(0, 99);
      if (r < 25) s_exc = 9'(1 << $urandom_range(0, 8));
      else if (r < 37) s_exc = 9'($urandom);
      s_pc   = {$urandom_range(0, 1) == 0 ? 16'h8000 : 16'hBFC0, 14'($urandom), 2'b00};
      s_ds   = 1'($urandom);
      s_alu  = $urandom;
      s_wr   = ($urandom_range(0, 99) < 30);
      s_dst  = pick_reg();
      s_outb = (s_dst == 5'd11) ? m_count + $urandom_range(0, 12) : $urandom;
      if ($urandom_range(0, 99) < 20) s_ext = 6'($urandom);
      s_rst  = ($urandom_range(0, 99) == 0);
      apply();
    end

    idle(5'd0);
    drive();
    repeat (3) @(negedge clk);
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
